mul_pipe_approx: RTL

Parametrised, pipelined unsigned multiplier with a valid/ready handshake. Each transaction selects exact or approximate mode; approximate mode drops the low partial-product columns (truncation).
Generalises the combinational 8-bit Wallace-tree multiplier into a WIDTH-generic, STAGES-deep, backpressure-aware datapath block. It sits between an operand producer and a result consumer in the multiplier test/characterisation path.

---
 rtl/mul_pipe_approx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mul_pipe_approx.sv
// Pipelined unsigned multiplier with valid/ready handshake and per-transaction truncated mode.
// Optional MUL_ERR_STATS_EN adds hand-off count and accumulated truncation-error outputs.
module mul_pipe_approx #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned TRUNC_COLS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               approx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               result_approx
`ifdef MUL_ERR_STATS_EN
    ,
    output logic [31:0]         stat_count,
    output logic [2*WIDTH+15:0] stat_err_sum
`endif
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned HALF  = WIDTH / 2;
    localparam int unsigned LAST  = STAGES - 1;
    localparam bit          SPLIT = (STAGES > 1);

    logic              stall;
    logic [PW-1:0]     col_mask_c;
    logic [PW-1:0]     row_c;
    logic [PW-1:0]     lo_sum_c;
    logic [PW-1:0]     hi_sum_c;
    logic [STAGES-1:0] s_valid;
    logic [STAGES-1:0] s_apx;
    logic [PW-1:0]     s_sum [STAGES];
    logic [PW-1:0]     s_part;

    assign stall         = s_valid[LAST] && !out_ready;
    assign in_ready      = !stall;
    assign out_valid     = s_valid[LAST];
    assign result        = s_sum[LAST];
    assign result_approx = s_apx[LAST];

    // Row j holds pp[i][j] at column i+j; truncation clears every column below TRUNC_COLS.
    always_comb begin
        col_mask_c = '0;
        row_c      = '0;
        lo_sum_c   = '0;
        hi_sum_c   = '0;
        for (int unsigned c = 0; c < PW; c++) begin
            col_mask_c[c] = (c >= TRUNC_COLS) || !approx;
        end
        for (int unsigned j = 0; j < WIDTH; j++) begin
            row_c = b[j] ? (PW'(a) << j) : '0;
            row_c = row_c & col_mask_c;
            if (j < HALF) begin
                lo_sum_c = lo_sum_c + row_c;
            end else begin
                hi_sum_c = hi_sum_c + row_c;
            end
        end
    end

    // Stage 0 registers two half-row partial sums, stage 1 merges them, later stages delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid <= '0;
            s_apx   <= '0;
            s_part  <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                s_sum[k] <= '0;
            end
        end else if (!stall) begin
            s_valid[0] <= in_valid;
            if (in_valid) begin
                s_apx[0] <= approx;
                if (SPLIT) begin
                    s_sum[0] <= lo_sum_c;
                    s_part   <= hi_sum_c;
                end else begin
                    s_sum[0] <= lo_sum_c + hi_sum_c;
                end
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                s_valid[k] <= s_valid[k-1];
                if (s_valid[k-1]) begin
                    s_apx[k] <= s_apx[k-1];
                    s_sum[k] <= (k == 1) ? (s_sum[0] + s_part) : s_sum[k-1];
                end
            end
        end
    end

`ifdef MUL_ERR_STATS_EN
    localparam int unsigned SW  = PW + 16;
    localparam int unsigned SW1 = SW + 1;

    logic [PW-1:0]  s_exact [STAGES];
    logic [PW-1:0]  err_c;
    logic [SW1-1:0] err_sum_c;

    // Exact shadow product travels in lock-step with the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                s_exact[k] <= '0;
            end
        end else if (!stall) begin
            if (in_valid) begin
                s_exact[0] <= PW'(a) * PW'(b);
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (s_valid[k-1]) begin
                    s_exact[k] <= s_exact[k-1];
                end
            end
        end
    end

    always_comb begin
        err_c     = s_exact[LAST] - s_sum[LAST];
        err_sum_c = {1'b0, stat_err_sum} + SW1'(err_c);
    end

    // Saturating statistics, updated on each result hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_count   <= '0;
            stat_err_sum <= '0;
        end else if (out_valid && out_ready) begin
            if (stat_count != '1) begin
                stat_count <= stat_count + 32'd1;
            end
            stat_err_sum <= err_sum_c[SW] ? '1 : err_sum_c[SW-1:0];
        end
    end
`endif

endmodule
